// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchroniser and stability counter producing clean switch levels plus rise/fall strobes.
// Optional SWDB_EVENT_COUNT_EN adds an 8-bit saturating count of accepted rises on bit 0.
module switch_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Clean,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall,
    output logic             Changed
`ifdef SWDB_EVENT_COUNT_EN
    ,
    output logic [7:0]       Event_count
`endif
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;

    // A bit is accepted when the synced level has disagreed with Clean for the full window.
    always_comb begin
        w_diff = r_s2 ^ r_clean;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == LP_LAST);
        end
        w_rise_nxt = w_accept & r_s2;
        w_fall_nxt = w_accept & ~r_s2;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_clean   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= SW;
            r_s2      <= r_s1;
            r_clean   <= r_clean ^ w_accept;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= |w_accept;
            // Any agreement with Clean (bounce back) restarts qualification.
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign Clean   = r_clean;
    assign Rise    = r_rise;
    assign Fall    = r_fall;
    assign Changed = r_changed;

`ifdef SWDB_EVENT_COUNT_EN
    logic [7:0] r_event_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_event_count <= 8'h00;
        end else if (w_rise_nxt[0] && (r_event_count != 8'hFF)) begin
            r_event_count <= r_event_count + 8'h01;
        end
    end

    assign Event_count = r_event_count;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=2; expected strobes are queued with their edge number.
// Define SWDB_EVENT_COUNT_EN for both files to exercise the rise event counter.
module tb_switch_debouncer;

  localparam int W   = 2;
  localparam int DB  = 4;
  localparam int EXP_W = 21;  // {edge[15:0], changed, rise[1:0], fall[1:0]}

  logic         Clk;
  logic         Reset;
  logic [W-1:0] SW;
  logic [W-1:0] Clean;
  logic [W-1:0] Rise;
  logic [W-1:0] Fall;
  logic         Changed;
`ifdef SWDB_EVENT_COUNT_EN
  logic [7:0]   Event_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int ev_exp  = 0;
  logic [W-1:0] model = '0;
  logic [EXP_W-1:0] exp_q[$];

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .SW(SW),
    .Clean(Clean),
    .Rise(Rise),
    .Fall(Fall),
    .Changed(Changed)
`ifdef SWDB_EVENT_COUNT_EN
    ,
    .Event_count(Event_count)
`endif
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) edge_n <= edge_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard: every strobe cycle must match the head of exp_q, including its edge number
  always @(negedge Clk) begin
    if (!Reset) begin
      logic [EXP_W-1:0] obs;
      logic [EXP_W-1:0] exp;
      n_tests++;
      if (Changed !== |(Rise | Fall)) begin
        n_fail++;
        $display("FAIL changed_or: Changed=%b required=%b (Rise=%b Fall=%b)", Changed, |(Rise | Fall), Rise, Fall);
      end
      obs = {16'(edge_n), Changed, Rise, Fall};
      if ((Rise | Fall) !== 2'b00 || Changed !== 1'b0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got %h (edge %0d) with nothing expected", obs, edge_n);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL strobe: got %h required %h", obs, exp);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0][20:5] < 16'(edge_n)) begin
        n_tests++;
        n_fail++;
        exp = exp_q.pop_front();
        $display("FAIL missed_strobe: got none at edge %0d required %h", edge_n, exp);
      end
    end
  end

  // driver tasks (call at a negedge)
  task automatic drive_sw(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [W-1:0] f;
    int e0;
    r  = v & ~model;
    f  = ~v & model;
    e0 = edge_n + 1;
    SW = v;
    if ((r | f) != 2'b00) exp_q.push_back({16'(e0 + DB + 1), 1'b1, r, f});
    if (r[0] && ev_exp < 255) ev_exp++;
    model = v;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge Clk);
      t++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_timeout: %0d strobes pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    SW    = '0;
    repeat (3) @(negedge Clk);
    n_tests++;
    if ({Clean, Rise, Fall, Changed} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000", {Clean, Rise, Fall, Changed});
    end
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      n_tests++;
      if (Clean !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_clean: cycle %0d got %b required 00", i, Clean);
      end
    end
  endtask

  task automatic test_single_rise();
    int e0;
    e0 = edge_n + 1;
    drive_sw(2'b01);
    repeat (DB + 1) @(negedge Clk);
    n_tests++;
    if (Clean !== 2'b00) begin
      n_fail++;
      $display("FAIL rise_early: edge %0d got %b required 00", edge_n - e0, Clean);
    end
    @(negedge Clk);
    n_tests++;
    if (Clean !== 2'b01) begin
      n_fail++;
      $display("FAIL rise_clean: edge %0d got %b required 01", edge_n - e0, Clean);
    end
    wait_idle();
    drive_sw(2'b00);
    wait_idle();
    n_tests++;
    if (Clean !== 2'b00) begin
      n_fail++;
      $display("FAIL fall_clean: got %b required 00", Clean);
    end
  endtask

  task automatic test_bounce();
    int e0;
    // three-cycle pulse is rejected
    SW = 2'b01;
    repeat (DB - 1) @(negedge Clk);
    SW = 2'b00;
    repeat (12) @(negedge Clk);
    n_tests++;
    if (Clean !== 2'b00) begin
      n_fail++;
      $display("FAIL bounce_short: got %b required 00", Clean);
    end
    // four-cycle pulse is just long enough
    e0 = edge_n + 1;
    SW = 2'b01;
    exp_q.push_back({16'(e0 + DB + 1), 1'b1, 2'b01, 2'b00});
    exp_q.push_back({16'(e0 + DB + DB + 1), 1'b1, 2'b00, 2'b01});
    if (ev_exp < 255) ev_exp++;
    repeat (DB) @(negedge Clk);
    SW = 2'b00;
    wait_idle();
    n_tests++;
    if (Clean !== 2'b00) begin
      n_fail++;
      $display("FAIL bounce_exact: got %b required 00", Clean);
    end
  endtask

  task automatic test_both();
    drive_sw(2'b11);
    wait_idle();
    n_tests++;
    if (Clean !== 2'b11) begin
      n_fail++;
      $display("FAIL both_clean: got %b required 11", Clean);
    end
    drive_sw(2'b01);
    wait_idle();
    n_tests++;
    if (Clean !== 2'b01) begin
      n_fail++;
      $display("FAIL bit1_fall_clean: got %b required 01", Clean);
    end
    drive_sw(2'b00);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int e0;
    drive_sw(2'b10);
    wait_idle();
    SW = 2'b11;
    repeat (DB) @(negedge Clk);  // bit 0 counter now at 2
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if ({Clean, Rise, Fall, Changed} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b required 0000000", {Clean, Rise, Fall, Changed});
    end
    exp_q.delete();
    model  = '0;
    ev_exp = 0;
    @(negedge Clk);
    Reset = 1'b0;
    e0 = edge_n + 1;
    drive_sw(2'b11);
    repeat (DB + 1) @(negedge Clk);
    n_tests++;
    if (Clean !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_early: got %b required 00", Clean);
    end
    @(negedge Clk);
    n_tests++;
    if (Clean !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset_clean: edge %0d got %b required 11", edge_n - e0, Clean);
    end
    wait_idle();
    drive_sw(2'b00);
    wait_idle();
  endtask

`ifdef SWDB_EVENT_COUNT_EN
  task automatic test_event_count();
    n_tests++;
    if (Event_count !== 8'(ev_exp)) begin
      n_fail++;
      $display("FAIL event_start: got %0d required %0d", Event_count, ev_exp);
    end
    for (int k = 0; k < 300; k++) begin
      drive_sw(2'b01);
      wait_idle();
      n_tests++;
      if (Event_count !== 8'(ev_exp)) begin
        n_fail++;
        $display("FAIL event_count: toggle %0d got %0d required %0d", k, Event_count, ev_exp);
      end
      drive_sw(2'b00);
      wait_idle();
    end
    n_tests++;
    if (Event_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL event_saturate: got %h required ff", Event_count);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1;
    SW    = '0;
    test_reset();
    test_single_rise();
    test_bounce();
    test_both();
    test_reset_mid();
`ifdef SWDB_EVENT_COUNT_EN
    test_event_count();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d strobes pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
